// File: rtl/downsample_sequencer.sv
// Walks every 2x2 block of the input image, sums four reads, writes one averaged pixel.
// Define DOWNSAMPLE_ROUND_EN for round-half-up averaging; default build truncates.
module downsample_sequencer #(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start_process,
   input  logic              pause,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              end_process,
   output logic [1:0]        status
);

   localparam int OW   = IMG_W / 2;
   localparam int OH   = IMG_H / 2;
   localparam int OX_W = (OW > 1) ? $clog2(OW) : 1;
   localparam int OY_W = (OH > 1) ? $clog2(OH) : 1;
   localparam logic [OX_W-1:0] OX_MAX = OX_W'(OW - 1);
   localparam logic [OY_W-1:0] OY_MAX = OY_W'(OH - 1);
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;
`ifdef DOWNSAMPLE_ROUND_EN
   localparam logic [DATA_W+1:0] ROUND_OFS = (DATA_W+2)'(2);
`else
   localparam logic [DATA_W+1:0] ROUND_OFS = '0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_RD, S_ACC, S_WR, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [OX_W-1:0]     r_ox;
   logic [OY_W-1:0]     r_oy;
   logic [1:0]          r_k;
   logic [DATA_W+1:0]   r_acc;
   logic                r_rd_vld;
   logic [DATA_W+1:0]   w_acc_sum;
   logic [ADDR_W-1:0]   w_rd_addr, w_wr_addr;
   logic                w_rd_en, w_wr_en, w_end, w_clr, w_last;
   logic [1:0]          w_status;

   // Offset of 2 before the shift gives round-half-up; 4*max+2 still fits DATA_W+2 bits.
   function automatic logic [DATA_W-1:0] f_average(input logic [DATA_W+1:0] i_sum);
      logic [DATA_W+1:0] v_t;
      v_t = i_sum + ROUND_OFS;
      return DATA_W'(v_t >> 2);
   endfunction

   // The datum returned on the same edge as the write is folded in via this bypass.
   assign w_acc_sum = r_acc + (r_rd_vld ? {2'b00, rd_data} : '0);
   assign w_rd_addr = ADDR_W'({r_oy, r_k[1]}) * ADDR_W'(IMG_W) + ADDR_W'({r_ox, r_k[0]});
   assign w_wr_addr = ADDR_W'(r_oy) * ADDR_W'(OW) + ADDR_W'(r_ox);
   assign w_last    = (r_ox == OX_MAX) && (r_oy == OY_MAX);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_wr_en     = 1'b0;
      w_end       = 1'b0;
      w_clr       = 1'b0;
      w_status    = ST_BUSY;
      case (r_state)
         S_IDLE: begin
            w_status = ST_IDLE;
            if (start_process) begin
               w_clr       = 1'b1;
               w_status    = ST_BUSY;
               w_state_nxt = S_RD;
            end
         end
         S_RD: begin
            if (!pause) begin
               w_rd_en = 1'b1;
               if (r_k == 2'd3) w_state_nxt = S_ACC;
            end
         end
         S_ACC: w_state_nxt = S_WR;
         S_WR: begin
            if (!pause) begin
               w_wr_en     = 1'b1;
               w_state_nxt = w_last ? S_DONE : S_RD;
            end
         end
         S_DONE: begin
            w_status    = ST_DONE;
            w_end       = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_en       <= 1'b0;
         rd_addr     <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         end_process <= 1'b0;
         status      <= ST_IDLE;
         r_rd_vld    <= 1'b0;
         r_acc       <= '0;
         r_k         <= '0;
         r_ox        <= '0;
         r_oy        <= '0;
      end else begin
         r_rd_vld    <= rd_en;
         rd_en       <= w_rd_en;
         wr_en       <= w_wr_en;
         end_process <= w_end;
         status      <= w_status;
         if (w_rd_en) rd_addr <= w_rd_addr;
         if (w_wr_en) begin
            wr_addr <= w_wr_addr;
            wr_data <= f_average(w_acc_sum);
         end
         if (w_clr || w_wr_en) begin
            r_acc <= '0;
            r_k   <= '0;
         end else begin
            r_acc <= w_acc_sum;
            if (w_rd_en) r_k <= r_k + 2'd1;
         end
         if (w_clr) begin
            r_ox <= '0;
            r_oy <= '0;
         end else if (w_wr_en) begin
            if (r_ox == OX_MAX) begin
               r_ox <= '0;
               r_oy <= (r_oy == OY_MAX) ? '0 : r_oy + 1'b1;
            end else begin
               r_ox <= r_ox + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_downsample_sequencer.sv
// Bench for downsample_sequencer on a 4x4 image: directed timing scenarios plus random frames.
module tb_downsample_sequencer;

   localparam int W = 4;
   localparam int H = 4;
   localparam int NPIX = (W / 2) * (H / 2);

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start_process = 1'b0;
   logic        pause = 1'b0;
   logic        rd_en, wr_en, end_process;
   logic [15:0] rd_addr, wr_addr;
   logic [7:0]  rd_data = 8'd0;
   logic [7:0]  wr_data;
   logic [1:0]  status;

   logic [7:0]  mem [0:15];
   int          cyc = 0;
   int          t0 = 0;
   bit          mon_on = 1'b0;
   int          rq_a[$], rq_c[$], wq_a[$], wq_d[$], wq_c[$], eq_c[$];
   logic [1:0]  st_log [0:79];
   int          checks = 0;
   int          errors = 0;

   downsample_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(16), .DATA_W(8)) dut (
      .clock(clock), .reset_n(reset_n), .start_process(start_process), .pause(pause),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .end_process(end_process), .status(status));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr[3:0]];

   always @(negedge clock) begin
      if (mon_on) begin
         int rel;
         rel = cyc - t0;
         if (rd_en) begin rq_a.push_back(int'(rd_addr)); rq_c.push_back(rel); end
         if (wr_en) begin
            wq_a.push_back(int'(wr_addr)); wq_d.push_back(int'(wr_data)); wq_c.push_back(rel);
         end
         if (end_process) eq_c.push_back(rel);
         if (rel >= 0 && rel < 80) st_log[rel] = status;
      end
   end

   // Reference: raster walk of 2x2 blocks and the average of their four pixels.
   function automatic int exp_addr(int p, int k);
      int ox, oy;
      ox = p % (W / 2);
      oy = p / (W / 2);
      return (2 * oy + k / 2) * W + 2 * ox + k % 2;
   endfunction

   function automatic int exp_data(int p);
      int s;
      s = 0;
      for (int k = 0; k < 4; k++) s += int'(mem[exp_addr(p, k)]);
`ifdef DOWNSAMPLE_ROUND_EN
      return (s + 2) / 4;
`else
      return s / 4;
`endif
   endfunction

   task automatic clear_logs();
      rq_a.delete(); rq_c.delete(); wq_a.delete(); wq_d.delete(); wq_c.delete(); eq_c.delete();
      for (int i = 0; i < 80; i++) st_log[i] = 2'bxx;
   endtask

   // pmode: 0 none, 1 pause edges 3..5, 2 pause edges 5..7, 3 restart pulse at 10, 4 random pause
   task automatic run_frame(input int pmode, output bit to);
      clear_logs();
      to = 1'b1;
      start_process = 1'b1;
      @(posedge clock); #1;
      start_process = 1'b0;
      t0 = cyc;
      mon_on = 1'b1;
      for (int n = 0; n < 600; n++) begin
         case (pmode)
            1: pause = (n + 1 >= 3 && n + 1 <= 5);
            2: pause = (n + 1 >= 5 && n + 1 <= 7);
            4: pause = ($urandom_range(0, 3) == 0);
            default: pause = 1'b0;
         endcase
         start_process = (pmode == 3 && n + 1 == 10);
         @(posedge clock); #1;
         if (eq_c.size() > 0) begin to = 1'b0; break; end
      end
      pause = 1'b0;
      start_process = 1'b0;
      @(negedge clock);
      @(negedge clock);
      mon_on = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", rd_en); end
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
      checks++; if (end_process !== 1'b0) begin errors++; $display("FAIL reset_end got %b exp 0", end_process); end
      checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status got %b exp 00", status); end
      checks++; if (rd_addr !== 16'd0) begin errors++; $display("FAIL reset_rd_addr got %0d exp 0", rd_addr); end
      checks++; if (wr_addr !== 16'd0) begin errors++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
      checks++; if (wr_data !== 8'd0) begin errors++; $display("FAIL reset_wr_data got %0d exp 0", wr_data); end
      reset_n = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checks++; if (status !== 2'b00) begin errors++; $display("FAIL idle_status got %b exp 00", status); end
   endtask

   task automatic test_uniform();
      bit to;
      for (int i = 0; i < 16; i++) mem[i] = 8'd100;
      run_frame(0, to);
      checks++; if (to) begin errors++; $display("FAIL uni_timeout got 1 exp 0"); end
      checks++; if (rq_a.size() != 4 * NPIX) begin errors++; $display("FAIL uni_rd_count got %0d exp %0d", rq_a.size(), 4 * NPIX); end
      for (int i = 0; i < rq_a.size() && i < 4 * NPIX; i++) begin
         checks++; if (rq_a[i] != exp_addr(i / 4, i % 4)) begin errors++; $display("FAIL uni_rd_addr[%0d] got %0d exp %0d", i, rq_a[i], exp_addr(i / 4, i % 4)); end
         checks++; if (rq_c[i] != 6 * (i / 4) + 1 + i % 4) begin errors++; $display("FAIL uni_rd_cycle[%0d] got %0d exp %0d", i, rq_c[i], 6 * (i / 4) + 1 + i % 4); end
      end
      checks++; if (wq_a.size() != NPIX) begin errors++; $display("FAIL uni_wr_count got %0d exp %0d", wq_a.size(), NPIX); end
      for (int p = 0; p < wq_a.size() && p < NPIX; p++) begin
         checks++; if (wq_c[p] != 6 * (p + 1)) begin errors++; $display("FAIL uni_wr_cycle[%0d] got %0d exp %0d", p, wq_c[p], 6 * (p + 1)); end
         checks++; if (wq_a[p] != p) begin errors++; $display("FAIL uni_wr_addr[%0d] got %0d exp %0d", p, wq_a[p], p); end
         checks++; if (wq_d[p] != 100) begin errors++; $display("FAIL uni_wr_data[%0d] got %0d exp 100", p, wq_d[p]); end
      end
      checks++; if (eq_c.size() != 1) begin errors++; $display("FAIL uni_end_count got %0d exp 1", eq_c.size()); end
      if (eq_c.size() > 0) begin
         checks++; if (eq_c[0] != 6 * NPIX + 1) begin errors++; $display("FAIL uni_end_cycle got %0d exp %0d", eq_c[0], 6 * NPIX + 1); end
      end
      for (int c = 1; c <= 6 * NPIX; c++) begin
         checks++; if (st_log[c] !== 2'b01) begin errors++; $display("FAIL uni_status[%0d] got %b exp 01", c, st_log[c]); end
      end
      checks++; if (st_log[6 * NPIX + 1] !== 2'b10) begin errors++; $display("FAIL uni_status_done got %b exp 10", st_log[6 * NPIX + 1]); end
      checks++; if (st_log[6 * NPIX + 2] !== 2'b00) begin errors++; $display("FAIL uni_status_idle got %b exp 00", st_log[6 * NPIX + 2]); end
   endtask

   task automatic test_rounding();
      bit to;
      int exp0;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      mem[0] = 8'd1; mem[1] = 8'd2; mem[4] = 8'd2; mem[5] = 8'd2;
      mem[2] = 8'd255; mem[3] = 8'd255; mem[6] = 8'd255; mem[7] = 8'd255;
`ifdef DOWNSAMPLE_ROUND_EN
      exp0 = 2;
`else
      exp0 = 1;
`endif
      run_frame(0, to);
      checks++; if (to) begin errors++; $display("FAIL rnd_timeout got 1 exp 0"); end
      checks++; if (wq_d.size() != NPIX) begin errors++; $display("FAIL rnd_wr_count got %0d exp %0d", wq_d.size(), NPIX); end
      if (wq_d.size() == NPIX) begin
         checks++; if (wq_d[0] != exp0) begin errors++; $display("FAIL rnd_sum7 got %0d exp %0d", wq_d[0], exp0); end
         checks++; if (wq_d[1] != 255) begin errors++; $display("FAIL rnd_max got %0d exp 255", wq_d[1]); end
         for (int p = 2; p < NPIX; p++) begin
            checks++; if (wq_d[p] != exp_data(p)) begin errors++; $display("FAIL rnd_data[%0d] got %0d exp %0d", p, wq_d[p], exp_data(p)); end
         end
      end
   endtask

   task automatic test_pause();
      bit to;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      run_frame(1, to);
      checks++; if (to) begin errors++; $display("FAIL prd_timeout got 1 exp 0"); end
      checks++; if (rq_a.size() != 4 * NPIX) begin errors++; $display("FAIL prd_rd_count got %0d exp %0d", rq_a.size(), 4 * NPIX); end
      for (int i = 0; i < rq_a.size() && i < 4 * NPIX; i++) begin
         checks++; if (rq_a[i] != exp_addr(i / 4, i % 4)) begin errors++; $display("FAIL prd_rd_addr[%0d] got %0d exp %0d", i, rq_a[i], exp_addr(i / 4, i % 4)); end
      end
      checks++; if (wq_c.size() != NPIX) begin errors++; $display("FAIL prd_wr_count got %0d exp %0d", wq_c.size(), NPIX); end
      for (int p = 0; p < wq_c.size() && p < NPIX; p++) begin
         checks++; if (wq_c[p] != 6 * (p + 1) + 3) begin errors++; $display("FAIL prd_wr_cycle[%0d] got %0d exp %0d", p, wq_c[p], 6 * (p + 1) + 3); end
         checks++; if (wq_d[p] != exp_data(p)) begin errors++; $display("FAIL prd_wr_data[%0d] got %0d exp %0d", p, wq_d[p], exp_data(p)); end
      end
      if (eq_c.size() > 0) begin
         checks++; if (eq_c[0] != 6 * NPIX + 4) begin errors++; $display("FAIL prd_end_cycle got %0d exp %0d", eq_c[0], 6 * NPIX + 4); end
      end
      // One pause edge lands on the ACC step (no effect), two on the first WR step.
      run_frame(2, to);
      checks++; if (to) begin errors++; $display("FAIL pwr_timeout got 1 exp 0"); end
      checks++; if (wq_c.size() != NPIX) begin errors++; $display("FAIL pwr_wr_count got %0d exp %0d", wq_c.size(), NPIX); end
      for (int p = 0; p < wq_c.size() && p < NPIX; p++) begin
         checks++; if (wq_c[p] != 6 * (p + 1) + 2) begin errors++; $display("FAIL pwr_wr_cycle[%0d] got %0d exp %0d", p, wq_c[p], 6 * (p + 1) + 2); end
         checks++; if (wq_d[p] != exp_data(p)) begin errors++; $display("FAIL pwr_wr_data[%0d] got %0d exp %0d", p, wq_d[p], exp_data(p)); end
      end
      if (eq_c.size() > 0) begin
         checks++; if (eq_c[0] != 6 * NPIX + 3) begin errors++; $display("FAIL pwr_end_cycle got %0d exp %0d", eq_c[0], 6 * NPIX + 3); end
      end
   endtask

   task automatic test_busy_start();
      bit to;
      for (int i = 0; i < 16; i++) mem[i] = 8'd100;
      run_frame(3, to);
      checks++; if (to) begin errors++; $display("FAIL busy_timeout got 1 exp 0"); end
      checks++; if (wq_c.size() != NPIX) begin errors++; $display("FAIL busy_wr_count got %0d exp %0d", wq_c.size(), NPIX); end
      for (int p = 0; p < wq_c.size() && p < NPIX; p++) begin
         checks++; if (wq_c[p] != 6 * (p + 1)) begin errors++; $display("FAIL busy_wr_cycle[%0d] got %0d exp %0d", p, wq_c[p], 6 * (p + 1)); end
         checks++; if (wq_a[p] != p) begin errors++; $display("FAIL busy_wr_addr[%0d] got %0d exp %0d", p, wq_a[p], p); end
      end
      checks++; if (eq_c.size() != 1) begin errors++; $display("FAIL busy_end_count got %0d exp 1", eq_c.size()); end
      if (eq_c.size() > 0) begin
         checks++; if (eq_c[0] != 6 * NPIX + 1) begin errors++; $display("FAIL busy_end_cycle got %0d exp %0d", eq_c[0], 6 * NPIX + 1); end
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      for (int i = 0; i < 16; i++) mem[i] = 8'd100;
      clear_logs();
      start_process = 1'b1;
      @(posedge clock); #1;
      start_process = 1'b0;
      t0 = cyc;
      mon_on = 1'b1;
      repeat (14) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      checks++; if ({rd_en, wr_en, end_process} !== 3'b000) begin errors++; $display("FAIL mid_strobes got %b exp 000", {rd_en, wr_en, end_process}); end
      checks++; if (status !== 2'b00) begin errors++; $display("FAIL mid_status got %b exp 00", status); end
      checks++; if ({rd_addr, wr_addr, wr_data} !== 40'd0) begin errors++; $display("FAIL mid_buses got %0h exp 0", {rd_addr, wr_addr, wr_data}); end
      repeat (8) @(posedge clock);
      #1;
      reset_n = 1'b1;
      repeat (8) @(posedge clock);
      #1;
      mon_on = 1'b0;
      checks++; if (wq_c.size() != 2) begin errors++; $display("FAIL mid_wr_count got %0d exp 2", wq_c.size()); end
      checks++; if (eq_c.size() != 0) begin errors++; $display("FAIL mid_end_count got %0d exp 0", eq_c.size()); end
      run_frame(0, to);
      checks++; if (to) begin errors++; $display("FAIL mid2_timeout got 1 exp 0"); end
      checks++; if (wq_c.size() != NPIX) begin errors++; $display("FAIL mid2_wr_count got %0d exp %0d", wq_c.size(), NPIX); end
      for (int p = 0; p < wq_c.size() && p < NPIX; p++) begin
         checks++; if (wq_c[p] != 6 * (p + 1)) begin errors++; $display("FAIL mid2_wr_cycle[%0d] got %0d exp %0d", p, wq_c[p], 6 * (p + 1)); end
         checks++; if (wq_d[p] != 100) begin errors++; $display("FAIL mid2_wr_data[%0d] got %0d exp 100", p, wq_d[p]); end
      end
      if (eq_c.size() > 0) begin
         checks++; if (eq_c[0] != 6 * NPIX + 1) begin errors++; $display("FAIL mid2_end_cycle got %0d exp %0d", eq_c[0], 6 * NPIX + 1); end
      end
   endtask

   task automatic test_random();
      bit to;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
         run_frame(4, to);
         checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout got 1 exp 0", f); end
         checks++; if (rq_a.size() != 4 * NPIX) begin errors++; $display("FAIL rand%0d_rd_count got %0d exp %0d", f, rq_a.size(), 4 * NPIX); end
         for (int i = 0; i < rq_a.size() && i < 4 * NPIX; i++) begin
            checks++; if (rq_a[i] != exp_addr(i / 4, i % 4)) begin errors++; $display("FAIL rand%0d_rd_addr[%0d] got %0d exp %0d", f, i, rq_a[i], exp_addr(i / 4, i % 4)); end
         end
         checks++; if (wq_a.size() != NPIX) begin errors++; $display("FAIL rand%0d_wr_count got %0d exp %0d", f, wq_a.size(), NPIX); end
         for (int p = 0; p < wq_a.size() && p < NPIX; p++) begin
            checks++; if (wq_a[p] != p) begin errors++; $display("FAIL rand%0d_wr_addr[%0d] got %0d exp %0d", f, p, wq_a[p], p); end
            checks++; if (wq_d[p] != exp_data(p)) begin errors++; $display("FAIL rand%0d_wr_data[%0d] got %0d exp %0d", f, p, wq_d[p], exp_data(p)); end
         end
         checks++; if (eq_c.size() != 1) begin errors++; $display("FAIL rand%0d_end_count got %0d exp 1", f, eq_c.size()); end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_uniform();
      test_rounding();
      test_pause();
      test_busy_start();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
